// File: rtl/ram_read_ctrl_pkg.sv
// Shared types and widths for the RAM read controller.
// Optional build macro: RAM_RD_CNT_EN (adds a saturating read counter).
package ram_ctrl_pkg;
    localparam int CNT_W    = 3;
    localparam int RD_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } rd_state_t;
endpackage

// File: rtl/ram_read_ctrl_if.sv
// Request/RAM-side signal bundle for ram_read_ctrl.
// Optional build macro: RAM_RD_CNT_EN adds o_rd_cnt.
interface ram_read_ctrl_if #(
    parameter int SIZE_DATA = 8
);
    import ram_ctrl_pkg::*;

    logic                 i_rd_en;
    logic [SIZE_DATA-1:0] i_ram_data;
    logic                 o_rd_en;
    logic [SIZE_DATA-1:0] o_data_rd;
    logic                 o_done;
    logic                 o_busy;
`ifdef RAM_RD_CNT_EN
    logic [RD_CNT_W-1:0]  o_rd_cnt;

    modport master (
        input  i_rd_en, i_ram_data,
        output o_rd_en, o_data_rd, o_done, o_busy, o_rd_cnt
    );
    modport slave (
        output i_rd_en, i_ram_data,
        input  o_rd_en, o_data_rd, o_done, o_busy, o_rd_cnt
    );
`else
    modport master (
        input  i_rd_en, i_ram_data,
        output o_rd_en, o_data_rd, o_done, o_busy
    );
    modport slave (
        output i_rd_en, i_ram_data,
        input  o_rd_en, o_data_rd, o_done, o_busy
    );
`endif
endinterface

// File: rtl/ram_cycle_cnt.sv
// Loadable down-counter with zero flag; used for wait and done timing.
module ram_cycle_cnt
    import ram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/ram_read_ctrl.sv
// Read-side RAM controller: strobe, wait RD_LATENCY, capture, pulse done.
// Optional build macro: RAM_RD_CNT_EN (saturating o_rd_cnt of captures).
module ram_read_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int SIZE_DATA   = 8,
    parameter int RD_LATENCY  = 1,
    parameter int DONE_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    ram_read_ctrl_if.master bus
);
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("RD_LATENCY must be within 1..4");
    end
    if (DONE_CYCLES < 1 || DONE_CYCLES > 4) begin : g_bad_done
        $error("DONE_CYCLES must be within 1..4");
    end

    rd_state_t            state;
    logic                 rd_en_q;
    logic                 done_q;
    logic                 busy_q;
    logic [SIZE_DATA-1:0] data_q;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic             wait_zero;
    logic             done_zero;
    logic             capture;

    assign capture = (state == WAIT) && wait_zero;

    ram_cycle_cnt u_wait_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (state == REQ),
        .load_val (CNT_W'(RD_LATENCY - 1)),
        .dec      ((state == WAIT) && !wait_zero),
        .cnt      (wait_cnt),
        .zero     (wait_zero)
    );

    ram_cycle_cnt u_done_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (capture),
        .load_val (CNT_W'(DONE_CYCLES - 1)),
        .dec      ((state == DONE) && !done_zero),
        .cnt      (done_cnt),
        .zero     (done_zero)
    );

    // All outputs are registered alongside the state transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_rd_en) begin
                        state   <= REQ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= WAIT;
                    rd_en_q <= 1'b0;
                end
                WAIT: begin
                    if (wait_zero) begin
                        state  <= DONE;
                        data_q <= bus.i_ram_data;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_zero) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_data_rd = data_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = busy_q;

`ifdef RAM_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_cnt_q <= '0;
        end else if (capture && (rd_cnt_q != '1)) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign bus.o_rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_ram_read_ctrl.sv
// Bench for ram_read_ctrl: two instances (RD_LATENCY 1 and 3) vs a cycle-offset model.
// Optional build macro: RAM_RD_CNT_EN enables read-counter checks.
module tb_ram_read_ctrl;
    localparam int DC = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rd_en = 1'b0;
    logic [3:0] addr1 = '0;
    logic [3:0] addr3 = '0;
    logic [7:0] mem [16];

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    bit  chk_on = 1'b0;
    bit  cnt_chk = 1'b1;
    int  st1 [$];
    int  st3 [$];
    int  rises [2] = '{0, 0};

    always #5 clk = ~clk;

    ram_read_ctrl_if bus1 ();
    ram_read_ctrl_if bus3 ();

    assign bus1.i_rd_en = rd_en;
    assign bus3.i_rd_en = rd_en;

    ram_read_ctrl #(.SIZE_DATA(8), .RD_LATENCY(1), .DONE_CYCLES(DC)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    ram_read_ctrl #(.SIZE_DATA(8), .RD_LATENCY(3), .DONE_CYCLES(DC)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3)
    );

    // RAM stand-ins: word appears RD_LATENCY edges after the strobe,
    // and a deliberately wrong word otherwise so late/early capture shows.
    logic [7:0] p1  = '0;
    logic [7:0] p3a = '0;
    logic [7:0] p3b = '0;
    logic [7:0] p3c = '0;

    always @(posedge clk) begin
        p1  <= bus1.o_rd_en ? mem[addr1] : ~mem[addr1];
        p3a <= bus3.o_rd_en ? mem[addr3] : ~mem[addr3];
        p3b <= p3a;
        p3c <= p3b;
    end

    assign bus1.i_ram_data = p1;
    assign bus3.i_ram_data = p3c;

    wire [1:0] act_rd   = {bus3.o_rd_en, bus1.o_rd_en};
    wire [1:0] act_busy = {bus3.o_busy, bus1.o_busy};
    wire [1:0] act_done = {bus3.o_done, bus1.o_done};
    wire [7:0] act_data [2];
    assign act_data[0] = bus1.o_data_rd;
    assign act_data[1] = bus3.o_data_rd;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Model: k = edges since the request was accepted, -1 when idle.
    int         k      [2] = '{-1, -1};
    logic [7:0] pend   [2] = '{8'h0, 8'h0};
    logic [7:0] m_data [2] = '{8'h0, 8'h0};
    int         m_cnt  [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                k[d]      <= -1;
                m_data[d] <= 8'h0;
                m_cnt[d]  <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (k[d] < 0) begin
                    if (rd_en) k[d] <= 0;
                end else begin
                    if (k[d] == 0) pend[d] <= mem[(d == 0) ? addr1 : addr3];
                    if (k[d] == lat_of(d)) begin
                        m_data[d] <= pend[d];
                        if (m_cnt[d] < 65535) m_cnt[d] <= m_cnt[d] + 1;
                    end
                    k[d] <= (k[d] + 1 == 1 + lat_of(d) + DC) ? -1 : k[d] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        logic [1:0] pd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_on) begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("rd_en%0d", d), 32'(act_rd[d]), 32'(k[d] == 0));
                    check($sformatf("busy%0d", d), 32'(act_busy[d]), 32'(k[d] >= 0));
                    check($sformatf("done%0d", d), 32'(act_done[d]), 32'(k[d] > lat_of(d)));
                    check($sformatf("data%0d", d), 32'(act_data[d]), 32'(m_data[d]));
                end
`ifdef RAM_RD_CNT_EN
                if (cnt_chk) begin
                    check("rd_cnt1", 32'(bus1.o_rd_cnt), 32'(m_cnt[0]));
                    check("rd_cnt3", 32'(bus3.o_rd_cnt), 32'(m_cnt[1]));
                end
`endif
            end
            if (act_rd[0]) st1.push_back(cyc);
            if (act_rd[1]) st3.push_back(cyc);
            for (int d = 0; d < 2; d++)
                if (act_done[d] && !pd[d]) rises[d]++;
            pd = act_done;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int s1, s3, r1, bad, nd;
        logic pd1, pd3;
        fork
            compare_loop();
        join_none

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 1);

        #1;
        rst_n  = 1'b0;
        rd_en  = 1'b1;
        chk_on = 1'b1;
        #100;
        tick();
        check("rst_rd_en", 32'(bus1.o_rd_en), 0);
        check("rst_busy", 32'(bus1.o_busy), 0);
        check("rst_done", 32'(bus3.o_done), 0);
        check("rst_data", 32'(bus1.o_data_rd), 0);
        rst_n = 1'b1;
        rd_en = 1'b0;
        repeat (3) tick();

        // Single read on both instances.
        mem[3] = 8'hA5;
        mem[7] = 8'h5A;
        addr1  = 4'd3;
        addr3  = 4'd7;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("dir_rd1", 32'(bus1.o_rd_en), 32'(j == 0));
            check("dir_done1", 32'(bus1.o_done), 32'(j == 2 || j == 3));
            check("dir_data1", 32'(bus1.o_data_rd), (j >= 2) ? 32'hA5 : 32'h0);
            check("dir_rd3", 32'(bus3.o_rd_en), 32'(j == 0));
            check("dir_done3", 32'(bus3.o_done), 32'(j == 4 || j == 5));
            check("dir_data3", 32'(bus3.o_data_rd), (j >= 4) ? 32'h5A : 32'h0);
            tick();
        end

        // Requests during WAIT and DONE must be dropped.
        repeat (2) tick();
        s1 = st1.size();
        r1 = rises[0];
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ign_busy_req", 32'(bus1.o_busy), 1);
        tick();
        check("ign_busy_wait", 32'(bus1.o_busy), 1);
        rd_en = 1'b1;
        tick();
        check("ign_busy_done", 32'(bus1.o_busy), 1);
        rd_en = 1'b0;
        tick();
        check("ign_busy_done2", 32'(bus1.o_busy), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (10) tick();
        check("ign_strobes", 32'(st1.size() - s1), 1);
        check("ign_dones", 32'(rises[0] - r1), 1);

        // Back-to-back with the address stage stepping on done falling.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        addr1 = '0;
        addr3 = '0;
        pd1   = 1'b0;
        pd3   = 1'b0;
        s1    = st1.size();
        s3    = st3.size();
        rd_en = 1'b1;
        for (int t = 0; t < 200 && (st1.size() - s1) < 16; t++) begin
            tick();
            if (pd1 && !bus1.o_done) addr1 = addr1 + 1'b1;
            if (pd3 && !bus3.o_done) addr3 = addr3 + 1'b1;
            pd1 = bus1.o_done;
            pd3 = bus3.o_done;
        end
        rd_en = 1'b0;
        repeat (10) tick();
        check("b2b_strobes1", 32'(st1.size() - s1), 16);
        bad = 0;
        for (int i = s1 + 1; i < st1.size(); i++)
            if (st1[i] - st1[i-1] != 5) bad++;
        check("b2b_spacing1", 32'(bad), 0);
        bad = 0;
        for (int i = s3 + 1; i < st3.size(); i++)
            if (st3[i] - st3[i-1] != 7) bad++;
        check("b2b_spacing3", 32'(bad), 0);
        check("b2b_last_word", 32'(bus1.o_data_rd), 32'(mem[15]));

        // Random traffic; the compare process does the checking.
        repeat (300) begin
            tick();
            rd_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) addr1 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) addr3 = 4'($urandom);
        end
        rd_en = 1'b0;
        repeat (12) tick();

        // Reset while in WAIT aborts the transaction.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_data", 32'(bus1.o_data_rd), 0);
        check("abort_busy", 32'(bus1.o_busy), 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            tick();
            if (bus1.o_done) nd++;
        end
        check("abort_no_done", 32'(nd), 0);

`ifdef RAM_RD_CNT_EN
        repeat (3) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            repeat (8) tick();
        end
        check("cnt_three", 32'(bus1.o_rd_cnt), 3);
        cnt_chk = 1'b0;
        force u_dut1.rd_cnt_q = 16'hFFFF;
        tick();
        release u_dut1.rd_cnt_q;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (8) tick();
        check("cnt_saturate", 32'(bus1.o_rd_cnt), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_read_ctrl.md
Name: ram_read_ctrl

Overview:
- Read-side counterpart of the RAM write-data stage. Sits between the request source and SinglePort_RAM.
- On a read request it issues a one-cycle read strobe to the RAM and waits the RAM's read latency.
- It then captures the RAM output word, holds it stable on o_data_rd, and signals completion with o_done. The address is supplied separately by the RAM address stage.

Parameters:
- SIZE_DATA, 8, width of the RAM data word.
- RD_LATENCY, 1, cycles from the RAM-strobe cycle to valid RAM output; legal range 1..4.
- DONE_CYCLES, 2, number of cycles o_done stays high per transaction; legal range 1..4.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rd_en  input  1  read request, sampled only in IDLE.
- i_ram_data  input  SIZE_DATA  RAM o_data.
- o_rd_en  output  1  read strobe to RAM i_rd_en, also used by the address stage.
- o_data_rd  output  SIZE_DATA  captured read word, held until the next capture.
- o_done  output  1  transaction complete, high for DONE_CYCLES cycles.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Single clock i_clk; reset i_rst_n is asynchronous, active-low (fixed).
- Reset values: state=IDLE, o_rd_en=0, o_data_rd=0, o_done=0, o_busy=0, counters=0.
- Outputs are decoded from registered state, so there is no combinational path from input to output.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if i_rd_en=1 at a rising edge, go to REQ; otherwise stay.
- REQ: o_rd_en=1 for exactly one cycle. Load the wait counter with RD_LATENCY-1, then go to WAIT.
- WAIT: counter decrements each cycle. When counter=0, latch i_ram_data into o_data_rd at that edge, load the done counter with DONE_CYCLES-1, and go to DONE. WAIT therefore lasts RD_LATENCY cycles.
- DONE: o_done=1. Counter decrements each cycle; at 0 go to IDLE.
- Latency with RD_LATENCY=1: i_rd_en sampled at edge E0 gives o_rd_en high in cycle E0..E1, capture at E2, and o_done high from E2 for DONE_CYCLES cycles.
- Back-to-back: i_rd_en held high is re-sampled on the first IDLE cycle after DONE. Minimum period is 2+RD_LATENCY+DONE_CYCLES cycles.
- i_rd_en while busy (REQ/WAIT/DONE) is ignored; requests are neither queued nor counted.
- o_data_rd changes only at the capture edge and is otherwise stable, including in IDLE.
- Reset mid-operation: immediate return to reset values. o_data_rd clears to 0, and no o_done is produced for the aborted transaction.
- A parameter outside its legal range is a compile-time error (elaboration assertion).

Optional Feature:
- Macro: RAM_RD_CNT_EN.
- Defined: adds output o_rd_cnt [15:0], reset 0. It increments by 1 on each capture edge and saturates at 16'hFFFF (no wrap).
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum rd_state_t {IDLE, REQ, WAIT, DONE};
  - localparam CNT_W=3 for the wait/done counters;
  - RD_CNT_W=16.
- One sub-module, ram_cycle_cnt: a loadable down-counter with a zero flag, instantiated twice (wait and done). Everything else stays in ram_read_ctrl.

Test Plan:
- Reset check: hold i_rst_n=0 for 100 ns -> all outputs 0; i_rd_en=1 during reset causes no o_rd_en.
- Single read, RD_LATENCY=1: preload RAM addr 3 = 8'hA5, address stage at 3, pulse i_rd_en one cycle ->
  - o_rd_en high exactly 1 cycle, 1 cycle after the sample;
  - o_data_rd=8'hA5 two edges after the strobe edge;
  - o_done high 2 cycles.
- Latency sweep, RD_LATENCY=3: same stimulus -> capture and o_done delayed exactly 2 more cycles; RAM output sampled at the correct cycle (8'h5A at addr 7 returned, not a stale word).
- Ignored request: pulse i_rd_en during WAIT and again during DONE -> no second o_rd_en; o_busy=1 throughout; exactly one o_done.
- Back-to-back: hold i_rd_en=1, addresses 0..15 stepping after each negedge o_done ->
  - 16 strobes, each spaced 5 cycles apart (defaults);
  - o_data_rd sequence matches memory contents.
- Mid-transaction reset, then RAM_RD_CNT_EN: assert i_rst_n=0 in WAIT -> no capture, no o_done, o_data_rd=0. With the macro defined, 3 completed reads give o_rd_cnt=3; a forced preload of 16'hFFFF stays 16'hFFFF after one more read.
